imem_loader_ctrl: RTL and testbench
===================================

IMEM_LOADER_CTRL -- requirements
Module: imem_loader_ctrl

Interface
REQ-001 Parameter NB_INST, default 32: instruction word width.
REQ-002 Parameter NB_ADDR, default 7: instruction memory address width (2^NB_ADDR words).
REQ-003 Parameter NB_BYTE, default 8: width of the serial byte stream.
REQ-004 Parameter HALT_WORD, default 32'hF800_0000: end-of-program instruction.
REQ-005 i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 i_reset  in  1  asynchronous, active-low reset.
REQ-007 i_start  in  1  one-cycle request to begin a program load.
REQ-008 i_rx_valid  in  1  byte-stream valid.
REQ-009 i_rx_data  in  NB_BYTE  byte-stream data.
REQ-010 i_pc_addr  in  NB_ADDR  fetch address from the pipeline PC.
REQ-011 i_fetch_en  in  1  pipeline fetch request.
REQ-012 o_rx_ready  out  1  controller accepts a byte this cycle.
REQ-013 o_mem_addr  out  NB_ADDR  instruction memory address.
REQ-014 o_mem_data  out  NB_INST  instruction memory write data.
REQ-015 o_mem_wr  out  1  instruction memory write enable.
REQ-016 o_mem_rd  out  1  instruction memory read enable.
REQ-017 o_word_count  out  NB_ADDR+1  number of words written in the current or last load.
REQ-018 o_load_done  out  1  load complete; pipeline owns the memory.
REQ-019 o_overflow  out  1  load ended because memory was full, with no HALT_WORD received.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, WRITE and DONE.
REQ-021 A byte SHALL be accepted only on a cycle where i_rx_valid=1 and o_rx_ready=1.
REQ-022 o_rx_ready SHALL be 1 only in LOAD.
REQ-023 Assembly SHALL be big-endian: the first byte of a word goes to [31:24], the fourth byte to [7:0].
REQ-024 A 2-bit byte counter SHALL track bytes of the current word and wrap 3->0 when the fourth byte is accepted.
REQ-025 IDLE with i_start=1 -> LOAD on the next edge, clearing the byte counter, the word pointer, o_word_count, o_load_done and o_overflow.
REQ-026 Acceptance of the fourth byte in LOAD -> WRITE on the next edge.
REQ-027 WRITE SHALL last exactly one cycle, driving:
- o_mem_wr=1
- o_mem_addr = word pointer
- o_mem_data = assembled word
REQ-028 On the WRITE edge, the word pointer and o_word_count SHALL each increment by 1.
REQ-029 From WRITE, the FSM goes to DONE if the assembled word equals HALT_WORD; HALT_WORD itself SHALL be written to memory.
REQ-030 From WRITE, the FSM goes to DONE with o_overflow=1 if the word pointer was 2^NB_ADDR-1 and the word was not HALT_WORD.
REQ-031 In all other cases, WRITE -> LOAD.
REQ-032 If the last word of memory is HALT_WORD, the load SHALL end with o_overflow=0.
REQ-033 Write latency: the fourth byte is accepted at edge N; o_mem_wr is high from edge N to edge N+1; the next byte can be accepted at edge N+2.
REQ-034 In IDLE and DONE (pass-through), the outputs SHALL be:
- o_mem_addr = i_pc_addr
- o_mem_rd = i_fetch_en
- o_mem_wr = 0
REQ-035 In LOAD and WRITE, o_mem_rd SHALL be 0; fetch is blocked regardless of i_fetch_en.
REQ-036 o_load_done SHALL be 1 only in DONE.
REQ-037 DONE with i_start=1 -> LOAD, with the same clears as REQ-025.
REQ-038 i_start SHALL be ignored in LOAD and WRITE.
REQ-039 i_rx_valid SHALL be ignored outside LOAD; no data is lost because o_rx_ready=0 there.
REQ-040 A partial word (byte counter != 0) SHALL never be written.

Reset
REQ-041 While i_reset=0, asynchronously: state=IDLE; byte counter, word pointer, assembled word, o_word_count, o_load_done and o_overflow all 0.
REQ-042 During reset, o_mem_wr=0 and o_rx_ready=0; o_mem_addr and o_mem_rd follow the pass-through rule.
REQ-043 Reset asserted mid-load SHALL abort the load with no further writes; words already written remain in memory.

Verification
REQ-044 Reset, then i_fetch_en=1 with i_pc_addr=5 -> o_mem_rd=1, o_mem_addr=5, o_mem_wr=0, o_load_done=0.
REQ-045 i_start, then bytes 12 34 56 78 then F8 00 00 00 -> writes 32'h12345678@0 and 32'hF8000000@1; o_load_done=1, o_word_count=2, o_overflow=0.
REQ-046 Gapped i_rx_valid (one byte every 3 cycles) -> same result as REQ-045; o_mem_wr asserted exactly once per 4 accepted bytes.
REQ-047 Load 128 non-HALT words -> last write @127; then DONE with o_overflow=1 and o_word_count=128.
REQ-048 i_fetch_en=1 throughout a load -> o_mem_rd=0 in LOAD/WRITE; pass-through resumes the cycle DONE is entered.
REQ-049 Reset pulled low after 2 bytes of word 3 -> IDLE, no write @3; a new i_start reloads from address 0.

Source files
------------

// File: rtl/imem_loader_ctrl.sv
// Loads a program into the instruction memory from a byte stream, then hands the
// memory over to the pipeline fetch port until the next load request.
module imem_loader_ctrl #(
    parameter int                 NB_INST   = 32,
    parameter int                 NB_ADDR   = 7,
    parameter int                 NB_BYTE   = 8,
    parameter logic [NB_INST-1:0] HALT_WORD = 32'hF800_0000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_rx_valid,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic [NB_ADDR-1:0] i_pc_addr,
    input  logic               i_fetch_en,
    output logic               o_rx_ready,
    output logic [NB_ADDR-1:0] o_mem_addr,
    output logic [NB_INST-1:0] o_mem_data,
    output logic               o_mem_wr,
    output logic               o_mem_rd,
    output logic [NB_ADDR:0]   o_word_count,
    output logic               o_load_done,
    output logic               o_overflow
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t               state;
    logic [1:0]           byte_cnt;
    logic [NB_ADDR-1:0]   word_ptr;
    logic [NB_INST-1:0]   word_buf;
    logic                 pass_through;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            word_ptr     <= '0;
            word_buf     <= '0;
            o_word_count <= '0;
            o_load_done  <= 1'b0;
            o_overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        state        <= LOAD;
                        byte_cnt     <= '0;
                        word_ptr     <= '0;
                        o_word_count <= '0;
                        o_load_done  <= 1'b0;
                        o_overflow   <= 1'b0;
                    end
                end
                LOAD: begin
                    // Shift in big-endian: first byte ends up in the top byte lane.
                    if (i_rx_valid) begin
                        word_buf <= {word_buf[NB_INST-NB_BYTE-1:0], i_rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) state <= WRITE;
                    end
                end
                WRITE: begin
                    word_ptr     <= word_ptr + 1'b1;
                    o_word_count <= o_word_count + 1'b1;
                    if (word_buf == HALT_WORD) begin
                        state       <= DONE;
                        o_load_done <= 1'b1;
                    end else if (word_ptr == {NB_ADDR{1'b1}}) begin
                        state       <= DONE;
                        o_load_done <= 1'b1;
                        o_overflow  <= 1'b1;
                    end else begin
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory port is muxed between the loader and the pipeline by state alone.
    always_comb begin
        pass_through = (state == IDLE) || (state == DONE);
        o_rx_ready   = (state == LOAD);
        o_mem_wr     = (state == WRITE);
        o_mem_data   = word_buf;
        o_mem_addr   = pass_through ? i_pc_addr : word_ptr;
        o_mem_rd     = pass_through & i_fetch_en;
    end

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Randomised bench for imem_loader_ctrl: programs are generated as word lists and the
// expected write log, word count and overflow flag are derived from those lists.
module tb_imem_loader_ctrl;

    localparam int          NB_INST = 32;
    localparam int          NB_ADDR = 7;
    localparam int          NB_BYTE = 8;
    localparam int          DEPTH   = 1 << NB_ADDR;
    localparam logic [31:0] HALT    = 32'hF800_0000;

    logic               i_clk;
    logic               i_reset;
    logic               i_start;
    logic               i_rx_valid;
    logic [NB_BYTE-1:0] i_rx_data;
    logic [NB_ADDR-1:0] i_pc_addr;
    logic               i_fetch_en;
    logic               o_rx_ready;
    logic [NB_ADDR-1:0] o_mem_addr;
    logic [NB_INST-1:0] o_mem_data;
    logic               o_mem_wr;
    logic               o_mem_rd;
    logic [NB_ADDR:0]   o_word_count;
    logic               o_load_done;
    logic               o_overflow;

    int vectors     = 0;
    int miscompares = 0;
    int blk_err     = 0;
    int pt_err      = 0;
    logic [NB_ADDR+NB_INST-1:0] wr_q[$];
    logic [31:0]                stim_q[$];

    imem_loader_ctrl dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
        .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
        .i_pc_addr(i_pc_addr), .i_fetch_en(i_fetch_en),
        .o_rx_ready(o_rx_ready), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
        .o_mem_wr(o_mem_wr), .o_mem_rd(o_mem_rd), .o_word_count(o_word_count),
        .o_load_done(o_load_done), .o_overflow(o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Memory-side observer: logs every write and tallies fetch-port rule breaks.
    always @(negedge i_clk) begin
        if (o_mem_wr) wr_q.push_back({o_mem_addr, o_mem_data});
        if ((o_rx_ready || o_mem_wr) && o_mem_rd) blk_err++;
        if (!o_rx_ready && !o_mem_wr && (o_mem_rd !== i_fetch_en || o_mem_addr !== i_pc_addr))
            pt_err++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = w ^ 32'h1;
        return w;
    endfunction

    task automatic gen_prog(input int len, input bit halt_end);
        stim_q.delete();
        for (int i = 0; i < len - 1; i++) stim_q.push_back(rnd_word());
        stim_q.push_back(halt_end ? HALT : rnd_word());
    endtask

    // Reference: words are written in order until HALT (inclusive) or memory fills.
    task automatic model(output int n, output bit ovf);
        n = 0; ovf = 1'b0;
        for (int i = 0; i < stim_q.size(); i++) begin
            n = i + 1;
            if (stim_q[i] == HALT) return;
            if (n == DEPTH) begin ovf = 1'b1; return; end
        end
    endtask

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic pulse_start();
        wr_q.delete(); blk_err = 0; pt_err = 0;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        logic r;
        ok = 1'b0;
        repeat (gap) @(posedge i_clk);
        if (gap > 0) #1;
        i_rx_valid = 1'b1; i_rx_data = b;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge i_clk); r = o_rx_ready;
            @(posedge i_clk); #1;
            if (r) ok = 1'b1;
        end
        i_rx_valid = 1'b0; i_rx_data = $urandom;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL byte_accept: byte %h not accepted within budget", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gmin, input int gmax, output bit ok);
        ok = 1'b1;
        for (int b = 0; b < 4 && ok; b++)
            send_byte(w[31-8*b -: 8], int'($urandom_range(gmax, gmin)), ok);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge i_clk);
            if (o_load_done) ok = 1'b1;
        end
        @(posedge i_clk); #1;
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL load_done_timeout: o_load_done stayed 0"); end
    endtask

    // Loads stim_q and checks the write log and end-of-load status against the model.
    task automatic run_load(input string name, input int gmin, input int gmax);
        int n; bit ovf, ok; int bad;
        model(n, ovf);
        pulse_start();
        ok = 1'b1;
        for (int i = 0; i < n && ok; i++) send_word(stim_q[i], gmin, gmax, ok);
        if (!ok) return;
        wait_done(ok);
        vectors++;
        if (wr_q.size() !== n) begin
            miscompares++; $display("FAIL %s_nwrites: got %0d want %0d", name, wr_q.size(), n);
        end
        bad = 0;
        for (int i = 0; i < n && i < wr_q.size(); i++)
            if (wr_q[i] !== {NB_ADDR'(i), stim_q[i]}) begin
                if (bad == 0)
                    $display("FAIL %s_write: entry %0d got %h want %h", name, i, wr_q[i], {NB_ADDR'(i), stim_q[i]});
                bad++;
            end
        vectors++; if (bad != 0) miscompares++;
        vectors++;
        if (o_word_count !== (NB_ADDR+1)'(n)) begin
            miscompares++; $display("FAIL %s_count: got %0d want %0d", name, o_word_count, n);
        end
        vectors++;
        if (o_overflow !== ovf) begin
            miscompares++; $display("FAIL %s_overflow: got %0b want %0b", name, o_overflow, ovf);
        end
        vectors++;
        if (blk_err !== 0) begin
            miscompares++; $display("FAIL %s_fetch_block: %0d cycles with o_mem_rd during load", name, blk_err);
        end
        vectors++;
        if (pt_err !== 0) begin
            miscompares++; $display("FAIL %s_passthrough: %0d bad pass-through cycles", name, pt_err);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b0; i_start = 1'b0; i_rx_valid = 1'b0; i_rx_data = '0;
        i_fetch_en = 1'b1; i_pc_addr = 7'd5;
        #12;
        vectors++; if (o_rx_ready !== 1'b0) begin miscompares++; $display("FAIL rst_rx_ready: got %b want 0", o_rx_ready); end
        vectors++; if (o_mem_wr !== 1'b0) begin miscompares++; $display("FAIL rst_mem_wr: got %b want 0", o_mem_wr); end
        vectors++; if (o_mem_rd !== 1'b1) begin miscompares++; $display("FAIL rst_mem_rd: got %b want 1", o_mem_rd); end
        vectors++; if (o_word_count !== '0 || o_overflow !== 1'b0 || o_load_done !== 1'b0) begin
            miscompares++; $display("FAIL rst_status: cnt %0d ovf %b done %b want 0 0 0", o_word_count, o_overflow, o_load_done);
        end
        @(posedge i_clk); #1; i_reset = 1'b1;
        @(negedge i_clk);
        vectors++; if (o_mem_rd !== 1'b1 || o_mem_addr !== 7'd5) begin
            miscompares++; $display("FAIL idle_fetch: rd %b addr %0d want 1 5", o_mem_rd, o_mem_addr);
        end
        vectors++; if (o_mem_wr !== 1'b0 || o_load_done !== 1'b0) begin
            miscompares++; $display("FAIL idle_wr_done: wr %b done %b want 0 0", o_mem_wr, o_load_done);
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_basic_load();
        i_fetch_en = 1'b0;
        stim_q.delete(); stim_q.push_back(32'h1234_5678); stim_q.push_back(HALT);
        run_load("basic", 0, 0);
    endtask

    task automatic test_gapped();
        stim_q.delete(); stim_q.push_back(32'h1234_5678); stim_q.push_back(HALT);
        run_load("gapped", 2, 2);
    endtask

    task automatic test_write_latency();
        bit ok;
        pulse_start();
        for (int b = 0; b < 4; b++) send_byte(8'hA0 + 8'(b), 0, ok);
        @(negedge i_clk);
        vectors++; if (o_mem_wr !== 1'b1 || o_mem_addr !== 7'd0 || o_mem_data !== 32'hA0A1A2A3) begin
            miscompares++; $display("FAIL lat_write: wr %b addr %0d data %h want 1 0 a0a1a2a3", o_mem_wr, o_mem_addr, o_mem_data);
        end
        vectors++; if (o_rx_ready !== 1'b0) begin miscompares++; $display("FAIL lat_ready_write: got %b want 0", o_rx_ready); end
        @(negedge i_clk);
        vectors++; if (o_mem_wr !== 1'b0 || o_rx_ready !== 1'b1) begin
            miscompares++; $display("FAIL lat_reload: wr %b ready %b want 0 1", o_mem_wr, o_rx_ready);
        end
        vectors++; if (o_word_count !== 8'd1) begin miscompares++; $display("FAIL lat_count: got %0d want 1", o_word_count); end
        @(posedge i_clk); #1;
        send_word(HALT, 0, 0, ok);
        wait_done(ok);
    endtask

    task automatic test_overflow();
        i_fetch_en = 1'b1; i_pc_addr = $urandom;
        gen_prog(DEPTH, 1'b0);
        run_load("overflow", 0, 0);
    endtask

    task automatic test_restart();
        gen_prog(3, 1'b1);
        pulse_start();
        @(negedge i_clk);
        vectors++; if (o_word_count !== '0 || o_load_done !== 1'b0 || o_overflow !== 1'b0) begin
            miscompares++; $display("FAIL restart_clear: cnt %0d done %b ovf %b want 0 0 0", o_word_count, o_load_done, o_overflow);
        end
        @(posedge i_clk); #1;
        run_load("restart", 0, 1);
    endtask

    task automatic test_halt_last();
        gen_prog(DEPTH, 1'b1);
        run_load("halt_last", 0, 0);
    endtask

    task automatic test_start_ignored();
        bit ok;
        logic [31:0] w;
        w = rnd_word();
        pulse_start();
        send_byte(w[31:24], 0, ok); send_byte(w[23:16], 0, ok);
        i_start = 1'b1; @(posedge i_clk); #1; i_start = 1'b0;
        send_byte(w[15:8], 0, ok); send_byte(w[7:0], 0, ok);
        i_start = 1'b1; @(posedge i_clk); #1; i_start = 1'b0;
        send_word(HALT, 0, 0, ok);
        wait_done(ok);
        vectors++;
        if (wr_q.size() !== 2 || wr_q[0] !== {7'd0, w} || wr_q[1] !== {7'd1, HALT}) begin
            miscompares++; $display("FAIL start_ignored: %0d writes, first %h want %h", wr_q.size(), wr_q[0], {7'd0, w});
        end
    endtask

    task automatic test_reset_midload();
        bit ok;
        gen_prog(6, 1'b1);
        pulse_start();
        for (int i = 0; i < 3; i++) send_word(stim_q[i], 0, 1, ok);
        send_byte(stim_q[3][31:24], 0, ok); send_byte(stim_q[3][23:16], 0, ok);
        #2; i_reset = 1'b0; #1;
        vectors++; if (o_rx_ready !== 1'b0 || o_word_count !== '0) begin
            miscompares++; $display("FAIL midrst_state: ready %b cnt %0d want 0 0", o_rx_ready, o_word_count);
        end
        repeat (3) @(posedge i_clk);
        #1; i_reset = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        vectors++;
        if (wr_q.size() !== 3 || wr_q[2] !== {7'd2, stim_q[2]}) begin
            miscompares++; $display("FAIL midrst_writes: got %0d writes want 3", wr_q.size());
        end
        gen_prog(4, 1'b1);
        run_load("reload", 0, 2);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            i_fetch_en = 1'($urandom); i_pc_addr = $urandom;
            gen_prog(int'($urandom_range(12, 1)), 1'b1);
            run_load("random", 0, 3);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_gapped();
        test_write_latency();
        test_overflow();
        test_restart();
        test_halt_last();
        test_start_ignored();
        test_reset_midload();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
